rv_multicycle_ctrl: RTL
=======================

Name: rv_multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback around the instruction decoder, the ALU, the register file and a single shared memory port.
- Consumes the opcode and funct3 fields of the latched instruction plus the branch-compare result.
- Emits per-state enables and mux selects for the datapath.
- Owns the memory request/ready handshake and the trap on an illegal opcode or a memory timeout.

Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles for mem_ready before trapping; 8-bit counter; must be 1..255.
- RESET_STATE, 3'd0: encoding of FETCH, loaded on rst.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instruction bits [6:0] from the latched IR
- funct3  in  3  instruction bits [14:12] (load/store/branch type)
- br_taken  in  1  branch comparator result, valid in EXEC
- mem_ready  in  1  memory accepts/completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  request is a store
- mem_fetch  out  1  request is an instruction fetch (address = PC)
- mem_size  out  3  funct3 forwarded during MEM
- ir_we  out  1  latch instruction word
- pc_we  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result with bit0 cleared (JALR)
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = imm
- reg_we  out  1  register-file write
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = imm (LUI)
- state  out  3  current state, for debug
- trap  out  1  sticky fault flag
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Registered state; all outputs are a combinational function of the state and the latched opcode/funct3.
- Reset: state=FETCH; trap=0; trap_cause=0; wait counter=0. Every strobe is 0 during the reset cycle.
- After reset release, FETCH asserts mem_req=1 and mem_fetch=1.
- FETCH:
  - mem_req=1, mem_fetch=1.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0; go to DECODE.
  - mem_ready is accepted in the same cycle mem_req first rises.
- DECODE:
  - Opcode outside {R, I, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR} -> TRAP, trap_cause=1.
  - Otherwise -> EXEC.
- EXEC:
  - ALU selects per class:
    - R: a=rs1, b=rs2
    - I/LOAD/STORE/JALR: a=rs1, b=imm
    - AUIPC/JAL/BRANCH: a=PC, b=imm
  - BRANCH: pc_we=br_taken, pc_src=1; -> FETCH.
  - LOAD/STORE -> MEM.
  - All others -> WB.
- MEM:
  - mem_req=1, mem_we=(STORE), mem_size=funct3.
  - On mem_ready: LOAD -> WB, STORE -> FETCH.
- WB:
  - reg_we=1; wb_sel: R/I/AUIPC=0, LOAD=1, JAL/JALR=2, LUI=3.
  - JAL: additionally pc_we=1, pc_src=1.
  - JALR: additionally pc_we=1, pc_src=2.
  - -> FETCH.
- Cycle counts with zero-wait memory: R/I/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 3.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle mem_req=1 with mem_ready=0.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: -> TRAP, trap_cause=2.
  - mem_ready in the same cycle the counter hits the limit wins; no trap.
- TRAP:
  - All strobes 0; trap=1; trap_cause holds.
  - Exited only by rst.
- rst mid-transaction:
  - mem_req drops the next cycle; no ir_we, pc_we or reg_we is emitted in that cycle.
  - The memory side must tolerate the abandoned request.
- At most one of ir_we/reg_we per cycle.
- pc_we is never asserted in DECODE, MEM or TRAP.

Optional Feature:
- Macro: RV_CTRL_PERF_CNT_EN.
- Enabled:
  - Adds output instret[31:0], incremented on every transition back to FETCH (retire), wrapping modulo 2^32.
  - Adds output stall_cnt[31:0], incremented each cycle mem_req=1 and mem_ready=0.
  - Both clear on rst.
  - Neither counts in TRAP.
- Disabled: the ports and counters are absent; the FSM is unaffected.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (RTYPE, ITYPE, LOAD, STORE, BTYPE, LUI, AUIPC, JAL, JALR), values identical to those used by the decoder;
  - state encodings;
  - the pc_src, wb_sel and trap_cause enumerations.
- Sub-module rv_mem_wait_timer: 8-bit wait counter with clear/enable/timeout compare, instantiated once.

Test Plan:
- ADD (opcode 0110011), mem_ready tied 1 -> states 0,1,2,4,0; reg_we=1 only in WB with wb_sel=0; pc_we only in FETCH.
- LW (0000011, funct3=010), mem_ready low 3 cycles in MEM -> MEM held 4 cycles with mem_req=1, mem_size=010; WB with wb_sel=1; total 8 cycles.
- BEQ (1100011), br_taken=1 then 0 -> EXEC pc_we=1, pc_src=1 in the first case; pc_we=0 in the second; back to FETCH after 3 cycles.
- JALR (1100111) -> WB reg_we=1, wb_sel=2, pc_we=1, pc_src=2.
- Opcode 1111111 -> TRAP after DECODE, trap_cause=1, all strobes 0 for 20 cycles; rst=1 for one cycle -> FETCH with trap=0.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> TRAP with trap_cause=2 exactly 4 cycles after FETCH entry; repeat with mem_ready on cycle 4 -> no trap.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I multicycle controller.
package rv_pkg;

  localparam int unsigned WAIT_CNT_W = 8;
  localparam int unsigned PERF_CNT_W = 32;

  // Base opcodes, identical to the values the instruction decoder uses
  localparam logic [6:0] RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BTYPE = 7'b1100011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    TC_NONE        = 2'd0,
    TC_ILLEGAL     = 2'd1,
    TC_MEM_TIMEOUT = 2'd2
  } trap_cause_e;

  // True for every opcode class the controller knows how to sequence
  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      RTYPE, ITYPE, LOAD, STORE, BTYPE, LUI, AUIPC, JAL, JALR: is_legal_opcode = 1'b1;
      default:                                                 is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_mem_wait_timer.sv
// Memory wait-cycle counter; flags the cycle whose wait would reach MEM_TIMEOUT.
module rv_mem_wait_timer
  import rv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout_c
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority over counting a wait cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This wait cycle would be the MEM_TIMEOUT-th one without a response
  assign timeout_c = en && (cnt_q == WAIT_CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core (fetch/decode/exec/mem/wb + trap).
// Optional performance counters (instret, stall_cnt) with RV_CTRL_PERF_CNT_EN.
module rv_multicycle_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [2:0]  RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_fetch,
  output logic [2:0]  mem_size,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef RV_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] instret,
  output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);

  state_e      state_q, state_d;
  logic        trap_q, trap_d;
  trap_cause_e trap_cause_q, trap_cause_d;
  logic        wait_en;
  logic        wait_clr;
  logic        timeout_c;

  // A memory request is outstanding and not answered this cycle
  assign wait_en  = !rst && (state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready;
  assign wait_clr = (state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM);

  rv_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (wait_clr),
    .en        (wait_en),
    .timeout_c (timeout_c)
  );

  // Next state, trap capture and per-state datapath strobes; all quiet in reset
  always_comb begin
    state_d      = state_q;
    trap_d       = trap_q;
    trap_cause_d = trap_cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_fetch    = 1'b0;
    mem_size     = 3'd0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req   = 1'b1;
          mem_fetch = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            pc_src  = PC_PLUS4;
            state_d = ST_DECODE;
          end else if (timeout_c) begin
            state_d      = ST_TRAP;
            trap_d       = 1'b1;
            trap_cause_d = TC_MEM_TIMEOUT;
          end
        end
        ST_DECODE: begin
          if (is_legal_opcode(opcode)) begin
            state_d = ST_EXEC;
          end else begin
            state_d      = ST_TRAP;
            trap_d       = 1'b1;
            trap_cause_d = TC_ILLEGAL;
          end
        end
        ST_EXEC: begin
          case (opcode)
            RTYPE: begin
              alu_a_sel = 1'b0;
              alu_b_sel = 1'b0;
            end
            ITYPE, LOAD, STORE, JALR: begin
              alu_a_sel = 1'b0;
              alu_b_sel = 1'b1;
            end
            AUIPC, JAL, BTYPE: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
            end
            default: begin
              alu_a_sel = 1'b0;
              alu_b_sel = 1'b0;
            end
          endcase
          if (opcode == BTYPE) begin
            pc_we   = br_taken;
            pc_src  = PC_IMM;
            state_d = ST_FETCH;
          end else if (opcode == LOAD || opcode == STORE) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          mem_we   = (opcode == STORE);
          mem_size = funct3;
          if (mem_ready) begin
            state_d = (opcode == LOAD) ? ST_WB : ST_FETCH;
          end else if (timeout_c) begin
            state_d      = ST_TRAP;
            trap_d       = 1'b1;
            trap_cause_d = TC_MEM_TIMEOUT;
          end
        end
        ST_WB: begin
          reg_we  = 1'b1;
          state_d = ST_FETCH;
          case (opcode)
            LOAD: wb_sel = WB_LOAD;
            LUI:  wb_sel = WB_IMM;
            JAL: begin
              wb_sel = WB_PC4;
              pc_we  = 1'b1;
              pc_src = PC_IMM;
            end
            JALR: begin
              wb_sel = WB_PC4;
              pc_we  = 1'b1;
              pc_src = PC_ALU;
            end
            default: wb_sel = WB_ALU;
          endcase
        end
        ST_TRAP: begin
          state_d = ST_TRAP;
        end
        default: begin
          state_d = state_e'(RESET_STATE);
        end
      endcase
    end
  end

  // State and sticky trap registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= state_e'(RESET_STATE);
      trap_q       <= 1'b0;
      trap_cause_q <= TC_NONE;
    end else begin
      state_q      <= state_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

`ifdef RV_CTRL_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] instret_q, instret_d;
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Retire on every return to FETCH; stall on every unanswered request cycle
  always_comb begin
    instret_d   = instret_q;
    stall_cnt_d = stall_cnt_q;
    if (!rst && state_q != ST_FETCH && state_q != ST_TRAP && state_d == ST_FETCH) begin
      instret_d = instret_q + PERF_CNT_W'(1);
    end
    if (wait_en) begin
      stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      instret_q   <= instret_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign instret   = instret_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
